// File: rtl/rxdet_sched.sv
// Round-robin scheduler of per-lane receiver-detect requests onto one engine.
// Optional: RXDET_SCHED_RETRY_EN adds one retry after a negative result.
module rxdet_sched #(
  parameter int NUM_LANES   = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] lane_req,
  output logic [NUM_LANES-1:0] lane_ack,
  output logic [NUM_LANES-1:0] lane_det,
  output logic                 eng_start,
  output logic [LW-1:0]        eng_lane,
  input  logic                 eng_done,
  input  logic                 eng_result,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE, SETTLE, START, WAIT, RESP
  } state_t;

  state_t          state, state_n;
  logic [LW-1:0]   ptr;
  logic [LW-1:0]   gnt;
  logic            found;
  logic [SW-1:0]   scnt;
  logic [TW-1:0]   tcnt;
  logic            drop;
  logic            settle_end;
  logic            tmo;
  logic            finish;
  logic            keep;
  logic [LW-1:0]   lane_nxt;
`ifdef RXDET_SCHED_RETRY_EN
  logic            retried;
  logic            neg;
`endif

  // First requesting lane at or above the pointer, wrapping.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!found && lane_req[(int'(ptr) + i) % NUM_LANES]) begin
        found = 1'b1;
        gnt   = LW'((int'(ptr) + i) % NUM_LANES);
      end
    end
  end

  assign settle_end = (scnt == SW'(SETTLE_CYC - 1));
  assign tmo        = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign finish     = eng_done || tmo;
  assign keep       = !drop && lane_req[eng_lane];
  assign lane_nxt   = (eng_lane == LW'(NUM_LANES - 1)) ? '0 : eng_lane + 1'b1;
  assign eng_start  = (state == START);
  assign busy       = (state != IDLE);
`ifdef RXDET_SCHED_RETRY_EN
  assign neg        = eng_done ? !eng_result : 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (found) state_n = SETTLE;
      SETTLE:  if (settle_end) state_n = START;
      START:   state_n = WAIT;
      WAIT: begin
        if (finish) begin
          state_n = RESP;
`ifdef RXDET_SCHED_RETRY_EN
          if (neg && !retried) state_n = SETTLE;
`endif
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      eng_lane    <= '0;
      scnt        <= '0;
      tcnt        <= '0;
      drop        <= 1'b0;
      lane_ack    <= '0;
      lane_det    <= '0;
      timeout_err <= 1'b0;
`ifdef RXDET_SCHED_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      lane_ack <= '0;
      if ((state == SETTLE || state == START || state == WAIT) &&
          !lane_req[eng_lane])
        drop <= 1'b1;
      unique case (state)
        IDLE: begin
          if (found) begin
            eng_lane <= gnt;
            scnt     <= '0;
            drop     <= 1'b0;
`ifdef RXDET_SCHED_RETRY_EN
            retried  <= 1'b0;
`endif
          end
        end
        SETTLE: scnt <= scnt + 1'b1;
        START:  tcnt <= '0;
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (finish && !eng_done) timeout_err <= 1'b1;
          if (state_n == SETTLE) begin
            scnt <= '0;
`ifdef RXDET_SCHED_RETRY_EN
            retried <= 1'b1;
`endif
          end else if (finish && keep) begin
            // Ack and result become visible together in RESP.
            lane_ack           <= NUM_LANES'(1) << eng_lane;
            lane_det[eng_lane] <= eng_done & eng_result;
          end
        end
        RESP:    ptr <= lane_nxt;
        default: ;
      endcase
    end
  end

endmodule
